seg7_bin2bcd_seq: RTL and testbench

- Sequential binary-to-7-segment display driver: converts a BIN_W-bit unsigned value to DIGITS BCD digits with an iterative shift-add-3 (double-dabble) engine, then encodes the digits to active-low 7-segment codes.
- Adds a start/busy/done handshake, leading-zero blanking, overflow detection and fixed message modes (error text, dashes, blank).
- Sits between keyboard/application logic and the board's seven-segment displays. Outputs are registered and hold until the next completed conversion.

---
 rtl/seg7_bin2bcd_seq.sv | 190 +++++++++++++++++++
 tb/tb_seg7_bin2bcd_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_bin2bcd_seq.sv
// Sequential binary to 7-segment driver. A double-dabble engine converts an
// unsigned BIN_W-bit value into DIGITS BCD digits one bit per clock, then the
// digits (or a fixed message) are encoded to active-low segment patterns.
// Outputs are registered and hold until the next completed conversion.
module seg7_bin2bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      value,
  input  logic [1:0]            mode,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   segs
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  // 10^DIGITS, evaluated at elaboration; 64 bits covers DIGITS up to 8.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] LIMIT = pow10(DIGITS);

  // Segment patterns, bit order {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_O     = 7'b0100011;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;
  typedef enum logic [1:0] {MODE_DEC, MODE_ERR, MODE_DASH, MODE_BLANK} mode_t;

  function automatic logic [6:0] digit_code(input logic [3:0] d);
    logic [6:0] c;
    case (d)
      4'd0:    c = 7'b1000000;
      4'd1:    c = 7'b1111001;
      4'd2:    c = 7'b0100100;
      4'd3:    c = 7'b0110000;
      4'd4:    c = 7'b0011001;
      4'd5:    c = 7'b0010010;
      4'd6:    c = 7'b0000010;
      4'd7:    c = 7'b1111000;
      4'd8:    c = 7'b0000000;
      4'd9:    c = 7'b0010000;
      default: c = SEG_DASH;
    endcase
    return c;
  endfunction

  // "Erro" right-aligned on digits 3..0; anything higher stays blank.
  function automatic logic [6:0] err_code(input int k);
    logic [6:0] c;
    case (k)
      0:       c = SEG_O;
      1, 2:    c = SEG_R;
      3:       c = SEG_E;
      default: c = SEG_BLANK;
    endcase
    return c;
  endfunction

  state_t             state, state_next;
  logic [BIN_W-1:0]   bin_q;
  logic [BCD_W-1:0]   bcd_q, bcd_adj;
  logic [CNT_W-1:0]   cnt_q;
  mode_t              mode_q;
  logic               blz_q;
  logic               ovf_q;
  logic [7*DIGITS-1:0] segs_next;
  logic               ovf_next;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: BIN_W shift cycles, then a single update cycle.
  always_comb begin
    // NOTE: assign a default before the case so no path leaves a variable
    // unassigned; a missing default in always_comb infers a latch.
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(1)) state_next = UPDATE;
      UPDATE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Add-3 correction on every BCD nibble that is 5 or more, ahead of the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  // Conversion datapath: capture on acceptance, shift {bcd,bin} while in SHIFT.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (reset) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      mode_q <= MODE_DEC;
      blz_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          bin_q  <= value;
          bcd_q  <= '0;
          cnt_q  <= CNT_W'(BIN_W);
          mode_q <= mode_t'(mode);
          blz_q  <= blank_lz;
          ovf_q  <= ({{(64-BIN_W){1'b0}}, value} >= LIMIT);
        end
        SHIFT: begin
          bcd_q <= {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
          bin_q <= {bin_q[BIN_W-2:0], 1'b0};
          cnt_q <= cnt_q - CNT_W'(1);
          // A 1 leaving the top nibble means the result needs more digits.
          if (bcd_adj[BCD_W-1]) ovf_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Display encoding of the finished conversion according to the captured mode.
  always_comb begin
    logic       seen_nz;
    logic [3:0] nib;
    segs_next = '1;
    ovf_next  = 1'b0;
    seen_nz   = 1'b0;
    nib       = '0;
    case (mode_q)
      MODE_DEC: begin
        if (ovf_q) begin
          ovf_next = 1'b1;
          for (int k = 0; k < DIGITS; k++) segs_next[7*k +: 7] = SEG_DASH;
        end else begin
          // Walk from the most significant digit so leading zeros are known.
          for (int k = DIGITS - 1; k >= 0; k--) begin
            nib = bcd_q[4*k +: 4];
            if (nib != 4'd0) seen_nz = 1'b1;
            if (blz_q && !seen_nz && k != 0) segs_next[7*k +: 7] = SEG_BLANK;
            else                             segs_next[7*k +: 7] = digit_code(nib);
          end
        end
      end
      MODE_ERR:  for (int k = 0; k < DIGITS; k++) segs_next[7*k +: 7] = err_code(k);
      MODE_DASH: for (int k = 0; k < DIGITS; k++) segs_next[7*k +: 7] = SEG_DASH;
      default:   segs_next = '1;
    endcase
  end

  // Registered outputs: busy during the shift cycles, done and display on UPDATE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      segs     <= '1;
    end else begin
      busy <= (state == SHIFT);
      done <= (state == UPDATE);
      if (state == UPDATE) begin
        segs     <= segs_next;
        overflow <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_seg7_bin2bcd_seq.sv
// Directed bench for seg7_bin2bcd_seq: a 14-bit/4-digit instance and a
// 20-bit/6-digit instance sharing clock and reset.
module tb_seg7_bin2bcd_seq;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S9 = 7'b0010000,
                         SE = 7'b0000110, SR = 7'b0101111, SO = 7'b0100011,
                         SD = 7'b0111111, SB = 7'b1111111;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, blank_lz_a, busy_a, done_a, overflow_a;
  logic [13:0] value_a;
  logic [1:0]  mode_a;
  logic [27:0] segs_a;
  logic        start_b, blank_lz_b, busy_b, done_b, overflow_b;
  logic [19:0] value_b;
  logic [1:0]  mode_b;
  logic [41:0] segs_b;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seg7_bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .value(value_a), .mode(mode_a),
    .blank_lz(blank_lz_a), .busy(busy_a), .done(done_a), .overflow(overflow_a),
    .segs(segs_a));

  seg7_bin2bcd_seq #(.BIN_W(20), .DIGITS(6)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .value(value_b), .mode(mode_b),
    .blank_lz(blank_lz_b), .busy(busy_b), .done(done_b), .overflow(overflow_b),
    .segs(segs_b));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for done on instance A, counting edges and busy cycles.
  task automatic wait_done_a(input int budget, output int edges, output int busy_cycles);
    edges = 0;
    busy_cycles = 0;
    while (!done_a && edges < budget) begin
      @(posedge clk); #1;
      edges++;
      if (busy_a) busy_cycles++;
    end
  endtask

  task automatic wait_done_b(input int budget, output int edges, output int busy_cycles);
    edges = 0;
    busy_cycles = 0;
    while (!done_b && edges < budget) begin
      @(posedge clk); #1;
      edges++;
      if (busy_b) busy_cycles++;
    end
  endtask

  // One full conversion on A; inputs are scrambled after acceptance.
  task automatic convert_a(input logic [13:0] v, input logic [1:0] m, input logic blz,
                           input logic [27:0] exp_segs, input logic exp_ovf, input string tag);
    int edges, bc;
    @(negedge clk);
    start_a = 1'b1; value_a = v; mode_a = m; blank_lz_a = blz;
    @(posedge clk); #1;
    start_a = 1'b0; value_a = ~v; mode_a = ~m; blank_lz_a = ~blz;
    wait_done_a(40, edges, bc);
    check({tag, " done"}, done_a, 1'b1);
    check({tag, " latency"}, edges, 15);
    check({tag, " busy"}, bc, 14);
    check({tag, " segs"}, segs_a, exp_segs);
    check({tag, " ovf"}, overflow_a, exp_ovf);
    @(posedge clk); #1;
    check({tag, " done pulse"}, done_a, 1'b0);
    check({tag, " segs hold"}, segs_a, exp_segs);
  endtask

  task automatic convert_b(input logic [19:0] v, input logic [1:0] m, input logic blz,
                           input logic [41:0] exp_segs, input logic exp_ovf, input string tag);
    int edges, bc;
    @(negedge clk);
    start_b = 1'b1; value_b = v; mode_b = m; blank_lz_b = blz;
    @(posedge clk); #1;
    start_b = 1'b0; value_b = ~v;
    wait_done_b(60, edges, bc);
    check({tag, " done"}, done_b, 1'b1);
    check({tag, " latency"}, edges, 21);
    check({tag, " busy"}, bc, 20);
    check({tag, " segs"}, segs_b, exp_segs);
    check({tag, " ovf"}, overflow_b, exp_ovf);
  endtask

  initial begin
    int edges, bc, seen;
    reset = 1'b1;
    start_a = 1'b0; value_a = '0; mode_a = '0; blank_lz_a = 1'b0;
    start_b = 1'b0; value_b = '0; mode_b = '0; blank_lz_b = 1'b0;
    #3;
    check("rst busy", busy_a, 1'b0);
    check("rst done", done_a, 1'b0);
    check("rst ovf", overflow_a, 1'b0);
    check("rst segs", segs_a, {4{SB}});
    check("rst segs b", segs_b, {6{SB}});
    @(negedge clk); reset = 1'b0;

    // Basic decimal conversions and boundaries.
    convert_a(14'd1234,  2'd0, 1'b0, {S1, S2, S3, S4}, 1'b0, "dec1234");
    convert_a(14'd9999,  2'd0, 1'b0, {4{S9}},          1'b0, "dec9999");
    convert_a(14'd10000, 2'd0, 1'b0, {4{SD}},          1'b1, "dec10000");
    convert_a(14'd16383, 2'd0, 1'b0, {4{SD}},          1'b1, "dec16383");
    convert_a(14'd7,     2'd0, 1'b0, {S0, S0, S0, S7}, 1'b0, "dec7");

    // Leading-zero blanking.
    convert_a(14'd7,     2'd0, 1'b1, {SB, SB, SB, S7}, 1'b0, "lz7");
    convert_a(14'd0,     2'd0, 1'b1, {SB, SB, SB, S0}, 1'b0, "lz0");
    convert_a(14'd1000,  2'd0, 1'b1, {S1, S0, S0, S0}, 1'b0, "lz1000");
    convert_a(14'd10000, 2'd0, 1'b1, {4{SD}},          1'b1, "lzovf");

    // Message modes; overflow is cleared even for a large value.
    convert_a(14'd16383, 2'd1, 1'b0, {SE, SR, SR, SO}, 1'b0, "err");
    convert_a(14'd1234,  2'd2, 1'b0, {4{SD}},          1'b0, "dash");
    convert_a(14'd1234,  2'd3, 1'b0, {4{SB}},          1'b0, "blank");

    // start while busy is ignored.
    @(negedge clk);
    start_a = 1'b1; value_a = 14'd42; mode_a = 2'd0; blank_lz_a = 1'b0;
    @(posedge clk); #1; start_a = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); start_a = 1'b1; value_a = 14'd99;
    @(negedge clk); start_a = 1'b0;
    wait_done_a(40, edges, bc);
    check("busy-start done", done_a, 1'b1);
    check("busy-start segs", segs_a, {S0, S0, S4, S2});
    seen = 0;
    repeat (25) begin @(posedge clk); #1; if (done_a) seen++; end
    check("busy-start no 2nd", seen, 0);

    // Back-to-back: start held high through the done cycle.
    @(negedge clk);
    start_a = 1'b1; value_a = 14'd5; mode_a = 2'd0; blank_lz_a = 1'b0;
    @(posedge clk); #1; value_a = 14'd6;
    wait_done_a(40, edges, bc);
    check("b2b first lat", edges, 15);
    check("b2b first segs", segs_a, {S0, S0, S0, S5});
    @(posedge clk); #1; start_a = 1'b0;
    check("b2b done low", done_a, 1'b0);
    wait_done_a(40, edges, bc);
    check("b2b second lat", edges, 15);
    check("b2b second segs", segs_a, {S0, S0, S0, S6});

    // Reset in mid-conversion after an overflowed result is on display.
    convert_a(14'd10000, 2'd0, 1'b0, {4{SD}}, 1'b1, "pre-rst");
    @(negedge clk);
    start_a = 1'b1; value_a = 14'd1234; mode_a = 2'd0; blank_lz_a = 1'b0;
    @(posedge clk); #1; start_a = 1'b0;
    repeat (4) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("midrst busy", busy_a, 1'b0);
    check("midrst segs", segs_a, {4{SB}});
    check("midrst ovf", overflow_a, 1'b0);
    @(negedge clk); reset = 1'b0;
    seen = 0;
    repeat (25) begin @(posedge clk); #1; if (done_a) seen++; end
    check("midrst no done", seen, 0);
    convert_a(14'd4321, 2'd0, 1'b0, {S4, S3, S2, S1}, 1'b0, "postrst");

    // Wide instance: reset mid-conversion, then full conversions.
    @(negedge clk);
    start_b = 1'b1; value_b = 20'd999999; mode_b = 2'd0; blank_lz_b = 1'b0;
    @(posedge clk); #1; start_b = 1'b0;
    repeat (4) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("b midrst busy", busy_b, 1'b0);
    check("b midrst segs", segs_b, {6{SB}});
    @(negedge clk); reset = 1'b0;
    seen = 0;
    repeat (30) begin @(posedge clk); #1; if (done_b) seen++; end
    check("b midrst no done", seen, 0);
    convert_b(20'd999999,  2'd0, 1'b0, {6{S9}}, 1'b0, "b999999");
    convert_b(20'd1000000, 2'd0, 1'b0, {6{SD}}, 1'b1, "b1000000");
    convert_b(20'd12,      2'd0, 1'b1, {SB, SB, SB, SB, S1, S2}, 1'b0, "blz12");
    convert_b(20'd5,       2'd1, 1'b0, {SB, SB, SE, SR, SR, SO}, 1'b0, "berr");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
